// File: rtl/decoder.sv
// Binary-to-one-hot decoder with a same-cycle combinational output and a
// registered, enable-gated copy carrying valid and out-of-range flags.
module decoder #(
  parameter int ENCODE_WIDTH = 4,
  parameter int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ENCODE_WIDTH-1:0] in,
  input  logic                    en,
  output logic [DECODE_WIDTH-1:0] out,
  output logic [DECODE_WIDTH-1:0] out_q,
  output logic                    valid_q,
  output logic                    err_q
);

  // One extra bit so DECODE_WIDTH == 2^ENCODE_WIDTH is representable.
  localparam logic [ENCODE_WIDTH:0] DW_LIMIT = (ENCODE_WIDTH+1)'(DECODE_WIDTH);

  if (ENCODE_WIDTH < 1 || ENCODE_WIDTH > 8) begin : g_bad_encode_width
    $error("decoder: ENCODE_WIDTH must be in 1..8");
  end
  if (DECODE_WIDTH < 1 || DECODE_WIDTH > (1 << ENCODE_WIDTH)) begin : g_bad_decode_width
    $error("decoder: DECODE_WIDTH must be in 1..2^ENCODE_WIDTH");
  end

  logic out_of_range;

  assign out_of_range = ({1'b0, in} >= DW_LIMIT);

  // One-hot decode; indices beyond DECODE_WIDTH-1 match no line, giving zero.
  always_comb begin
    out = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (in == ENCODE_WIDTH'(k)) out[k] = 1'b1;
    end
  end

  // Capture on enable; out_q/err_q hold otherwise while valid_q drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      out_q   <= out;
      valid_q <= 1'b1;
      err_q   <= out_of_range;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: a full-range instance (4->16) and a partial
// instance (4->10) share stimulus; expected registered outputs are queued
// by the driver and checked by an independent monitor.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in;
  logic        en;
  logic [15:0] out16, out_q16;
  logic        valid_q16, err_q16;
  logic [9:0]  out10, out_q10;
  logic        valid_q10, err_q10;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] oq16;
    logic        v16;
    logic        e16;
    logic [9:0]  oq10;
    logic        v10;
    logic        e10;
  } exp_t;

  exp_t sb_q[$];

  // Reference state of the registered outputs.
  logic [15:0] m_oq16 = '0;
  logic        m_v16  = 1'b0;
  logic        m_e16  = 1'b0;
  logic [9:0]  m_oq10 = '0;
  logic        m_v10  = 1'b0;
  logic        m_e10  = 1'b0;

  always #5 clk = ~clk;

  decoder #(.ENCODE_WIDTH(4), .DECODE_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .out(out16), .out_q(out_q16), .valid_q(valid_q16), .err_q(err_q16)
  );

  decoder #(.ENCODE_WIDTH(4), .DECODE_WIDTH(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .out(out10), .out_q(out_q10), .valid_q(valid_q10), .err_q(err_q10)
  );

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Apply one cycle of stimulus, check the combinational output, and queue
  // the registered outputs expected after the coming rising edge.
  task automatic step(input logic r, input logic e, input int idx);
    exp_t x;
    int   exp10;
    @(negedge clk);
    rst_n = r;
    en    = e;
    in    = 4'(idx);
    #1;
    chk("out16", out16, 16'(1 << idx));
    exp10 = (idx < 10) ? (1 << idx) : 0;
    chk("out10", {6'b0, out10}, 16'(exp10));
    if (!r) begin
      m_oq16 = '0; m_v16 = 1'b0; m_e16 = 1'b0;
      m_oq10 = '0; m_v10 = 1'b0; m_e10 = 1'b0;
    end else if (e) begin
      m_oq16 = 16'(1 << idx); m_v16 = 1'b1; m_e16 = 1'b0;
      m_oq10 = 10'(exp10);    m_v10 = 1'b1; m_e10 = (idx >= 10);
    end else begin
      m_v16 = 1'b0;
      m_v10 = 1'b0;
    end
    x.oq16 = m_oq16; x.v16 = m_v16; x.e16 = m_e16;
    x.oq10 = m_oq10; x.v10 = m_v10; x.e10 = m_e10;
    sb_q.push_back(x);
  endtask

  // Monitor: after each rising edge, compare registered outputs to the
  // oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("out_q16",   out_q16,            e.oq16);
        chk("valid_q16", {15'b0, valid_q16}, {15'b0, e.v16});
        chk("err_q16",   {15'b0, err_q16},   {15'b0, e.e16});
        chk("out_q10",   {6'b0, out_q10},    {6'b0, e.oq10});
        chk("valid_q10", {15'b0, valid_q10}, {15'b0, e.v10});
        chk("err_q10",   {15'b0, err_q10},   {15'b0, e.e10});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    in    = '0;
    // Reset held with en high: registered outputs stay cleared.
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 3);
    // Single capture then hold.
    step(1'b1, 1'b1, 7);
    step(1'b1, 1'b0, 7);
    step(1'b1, 1'b0, 2);
    // Back-to-back captures.
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 2);
    // Out-of-range for the 10-line instance, then the top legal index.
    step(1'b1, 1'b1, 12);
    step(1'b1, 1'b1, 9);
    step(1'b1, 1'b0, 15);
    // Reset right after a capture, with en still high.
    step(1'b1, 1'b1, 4);
    step(1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 4);
    // Full index sweep, enabled.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i);
    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)));
    end
    repeat (3) @(posedge clk);
    #3;
    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
